// File: rtl/mips_mem_pkg.sv
// Shared encodings for the data-memory load/store path: access sizes, LSU states, word width.
package mips_mem_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_t;

  typedef enum logic {
    LSU_IDLE      = 1'b0,
    LSU_RMW_WRITE = 1'b1
  } lsu_state_t;

  // Reserved size encoding is handled exactly like a word access.
  function automatic size_t eff_size(input logic [1:0] sz);
    return (sz == 2'b11) ? SZ_WORD : size_t'(sz);
  endfunction

endpackage

// File: rtl/lsu_subword_ctrl_if.sv
// CPU request/response and data-memory port bundle for the load/store controller.
interface lsu_subword_ctrl_if;
  logic        req_valid;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [31:0] rdata;
  logic        stall;
  logic        misalign;
  logic [31:0] mem_addr;
  logic [31:0] mem_wd;
  logic        mem_we;
  logic [31:0] mem_rd;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rd,
    input  rdata, stall, misalign, mem_addr, mem_wd, mem_we
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rd,
    output rdata, stall, misalign, mem_addr, mem_wd, mem_we
  );
endinterface

// File: rtl/lsu_lane_align.sv
// Combinational lane logic: load extract/extend and store lane merge, endianness selectable.
module lsu_lane_align
  import mips_mem_pkg::*;
#(
  parameter int BIG_ENDIAN = 0
) (
  input  size_t              size,
  input  logic               zero_ext,
  input  logic [1:0]         offset,
  input  logic [WORD_W-1:0]  word,
  input  logic [WORD_W-1:0]  wdata,
  output logic [WORD_W-1:0]  load_data,
  output logic [WORD_W-1:0]  merged
);

  logic [1:0]        lane;
  logic [4:0]        shamt;
  logic [WORD_W-1:0] shifted;
  logic [WORD_W-1:0] mask;

  always_comb begin
    // Physical byte lane of the lowest addressed byte of the access.
    if (size == SZ_HALF)
      lane = (BIG_ENDIAN != 0) ? {~offset[1], 1'b0} : {offset[1], 1'b0};
    else
      lane = (BIG_ENDIAN != 0) ? ~offset : offset;
    shamt     = {lane, 3'b000};
    shifted   = word >> shamt;
    mask      = '0;
    load_data = word;
    merged    = wdata;
    case (size)
      SZ_BYTE: begin
        load_data = {{24{~zero_ext & shifted[7]}}, shifted[7:0]};
        mask      = 32'h0000_00FF << shamt;
        merged    = (word & ~mask) | ({24'b0, wdata[7:0]} << shamt);
      end
      SZ_HALF: begin
        load_data = {{16{~zero_ext & shifted[15]}}, shifted[15:0]};
        mask      = 32'h0000_FFFF << shamt;
        merged    = (word & ~mask) | ({16'b0, wdata[15:0]} << shamt);
      end
      default: begin
        load_data = word;
        merged    = wdata;
      end
    endcase
  end

endmodule

// File: rtl/lsu_subword_ctrl.sv
// Load/store controller: word passthrough, sub-word loads, 2-cycle RMW sub-word stores.
// Optional misalignment trap with sticky flag enabled by LSU_MISALIGN_TRAP_EN.
module lsu_subword_ctrl
  import mips_mem_pkg::*;
#(
  parameter int MEM_WORDS  = 64,
  parameter int BIG_ENDIAN = 0
) (
  input  logic                clk,
  input  logic                rst,
  lsu_subword_ctrl_if.slave   bus
);

  lsu_state_t        state, state_next;
  logic [WORD_W-1:0] merge_q, merge_d;
  size_t             size;
  logic [1:0]        offset;
  logic              mis_req;
  logic              in_range;
  logic              ok;
  logic [WORD_W-1:0] load_data, merged;
  logic              mem_we, stall;
  logic [WORD_W-1:0] mem_wd, rdata;

  assign size     = eff_size(bus.req_size);
  assign in_range = bus.req_addr[31:2] < 30'(MEM_WORDS);

`ifdef LSU_MISALIGN_TRAP_EN
  logic misalign_seen;

  assign mis_req = bus.req_valid &&
                   ((size == SZ_HALF && bus.req_addr[0]) ||
                    (size == SZ_WORD && bus.req_addr[1:0] != 2'b00));
  assign offset       = bus.req_addr[1:0];
  assign bus.misalign = !rst && (mis_req || misalign_seen);

  always_ff @(posedge clk) begin
    if (rst)          misalign_seen <= 1'b0;
    else if (mis_req) misalign_seen <= 1'b1;
  end
`else
  assign mis_req = 1'b0;
  // Misaligned half/word accesses are silently forced to their natural alignment.
  assign offset = (size == SZ_WORD) ? 2'b00 :
                  (size == SZ_HALF) ? {bus.req_addr[1], 1'b0} : bus.req_addr[1:0];
  assign bus.misalign = 1'b0;
`endif

  assign ok = bus.req_valid && !mis_req && in_range;

  lsu_lane_align #(.BIG_ENDIAN(BIG_ENDIAN)) u_align (
    .size      (size),
    .zero_ext  (bus.req_unsigned),
    .offset    (offset),
    .word      (bus.mem_rd),
    .wdata     (bus.req_wdata),
    .load_data (load_data),
    .merged    (merged)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= LSU_IDLE;
      merge_q <= '0;
    end else begin
      state   <= state_next;
      merge_q <= merge_d;
    end
  end

  always_comb begin
    state_next = state;
    merge_d    = merge_q;
    mem_we     = 1'b0;
    mem_wd     = bus.req_wdata;
    stall      = 1'b0;
    rdata      = '0;
    case (state)
      LSU_IDLE: begin
        if (ok) begin
          if (!bus.req_we) begin
            rdata = load_data;
          end else if (size == SZ_WORD) begin
            mem_we = 1'b1;
          end else begin
            stall      = 1'b1;
            merge_d    = merged;
            state_next = LSU_RMW_WRITE;
          end
        end
      end
      LSU_RMW_WRITE: begin
        // Completes even if req_valid dropped; mem_wd comes only from the register.
        mem_we     = 1'b1;
        mem_wd     = merge_q;
        state_next = LSU_IDLE;
      end
      default: state_next = LSU_IDLE;
    endcase
    if (rst) begin
      mem_we = 1'b0;
      stall  = 1'b0;
    end
  end

  assign bus.mem_addr = {bus.req_addr[31:2], 2'b00};
  assign bus.mem_wd   = mem_wd;
  assign bus.mem_we   = mem_we;
  assign bus.stall    = stall;
  assign bus.rdata    = rdata;

endmodule

// File: tb/tb_lsu_subword_ctrl.sv
// Directed self-checking bench for lsu_subword_ctrl with a small aliasing memory model.
module tb_lsu_subword_ctrl;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  lsu_subword_ctrl_if bus();

  lsu_subword_ctrl #(.MEM_WORDS(64), .BIG_ENDIAN(0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Memory model: 64 words, address decode ignores upper bits (aliases), so
  // out-of-range suppression must come from the DUT.
  logic [31:0] mem [0:63];
  logic        pre_en;
  logic [5:0]  pre_idx;
  logic [31:0] pre_val;

  always @(posedge clk) begin
    if (pre_en)          mem[pre_idx] <= pre_val;
    else if (bus.mem_we) mem[bus.mem_addr[7:2]] <= bus.mem_wd;
  end
  assign bus.mem_rd = mem[bus.mem_addr[7:2]];

  task automatic drive(input logic v, input logic we, input logic [1:0] sz,
                       input logic uns, input logic [31:0] a, input logic [31:0] wd);
    bus.req_valid    = v;
    bus.req_we       = we;
    bus.req_size     = sz;
    bus.req_unsigned = uns;
    bus.req_addr     = a;
    bus.req_wdata    = wd;
  endtask

  task automatic preload(input logic [5:0] idx, input logic [31:0] val);
    @(negedge clk);
    drive(0, 0, 2'b10, 0, 32'h0, 32'h0);
    pre_en = 1'b1; pre_idx = idx; pre_val = val;
    @(posedge clk);
    #1 pre_en = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    rst = 1'b1;
    drive(1, 1, 2'b00, 0, 32'h09, 32'hAA);
    #1;
    total++; if (bus.stall !== 1'b0) begin bad++; $display("FAIL rst_stall: got %b want 0", bus.stall); end
    total++; if (bus.mem_we !== 1'b0) begin bad++; $display("FAIL rst_mem_we: got %b want 0", bus.mem_we); end
    total++; if (bus.misalign !== 1'b0) begin bad++; $display("FAIL rst_misalign: got %b want 0", bus.misalign); end
    @(negedge clk);
    rst = 1'b0;
    drive(0, 0, 2'b10, 0, 32'h14, 32'h0);
    #1;
    total++; if (bus.stall !== 1'b0) begin bad++; $display("FAIL idle_stall: got %b want 0", bus.stall); end
    total++; if (bus.mem_we !== 1'b0) begin bad++; $display("FAIL idle_mem_we: got %b want 0", bus.mem_we); end
    total++; if (bus.rdata !== 32'h0) begin bad++; $display("FAIL idle_rdata: got %h want 0", bus.rdata); end
  endtask

  task automatic test_load_ext;
    logic [1:0]  sz  [8] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00, 2'b11};
    logic        uns [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [31:0] a   [8] = '{32'h16, 32'h16, 32'h14, 32'h16, 32'h16, 32'h17, 32'h15, 32'h14};
    logic [31:0] exp [8] = '{32'hFFFF_FF81, 32'h0000_0081, 32'h0000_7F02, 32'h0000_8081,
                             32'hFFFF_8081, 32'hFFFF_FF80, 32'h0000_007F, 32'h8081_7F02};
    preload(6'd5, 32'h8081_7F02);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      drive(1, 0, sz[i], uns[i], a[i], 32'h0);
      #1;
      total++; if (bus.rdata !== exp[i]) begin bad++; $display("FAIL load_%0d: got %h want %h", i, bus.rdata, exp[i]); end
      total++; if (bus.stall !== 1'b0 || bus.mem_we !== 1'b0) begin bad++; $display("FAIL load_ctl_%0d: got stall=%b we=%b want 0 0", i, bus.stall, bus.mem_we); end
    end
    total++; if (bus.mem_addr !== 32'h14) begin bad++; $display("FAIL load_addr: got %h want 00000014", bus.mem_addr); end
  endtask

  task automatic test_word_store;
    @(negedge clk);
    drive(1, 1, 2'b10, 0, 32'h08, 32'hDEAD_BEEF);
    #1;
    total++; if (bus.mem_we !== 1'b1) begin bad++; $display("FAIL sw_we: got %b want 1", bus.mem_we); end
    total++; if (bus.mem_wd !== 32'hDEAD_BEEF) begin bad++; $display("FAIL sw_wd: got %h want deadbeef", bus.mem_wd); end
    total++; if (bus.stall !== 1'b0) begin bad++; $display("FAIL sw_stall: got %b want 0", bus.stall); end
    @(negedge clk);
    drive(1, 0, 2'b10, 0, 32'h08, 32'h0);
    #1;
    total++; if (bus.rdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL sw_readback: got %h want deadbeef", bus.rdata); end
  endtask

  task automatic test_byte_rmw;
    preload(6'd2, 32'h1122_3344);
    @(negedge clk);
    drive(1, 1, 2'b00, 0, 32'h09, 32'h0000_00AA);
    #1;
    total++; if (bus.stall !== 1'b1) begin bad++; $display("FAIL sb_c1_stall: got %b want 1", bus.stall); end
    total++; if (bus.mem_we !== 1'b0) begin bad++; $display("FAIL sb_c1_we: got %b want 0", bus.mem_we); end
    @(negedge clk);
    #1;
    total++; if (bus.mem_we !== 1'b1) begin bad++; $display("FAIL sb_c2_we: got %b want 1", bus.mem_we); end
    total++; if (bus.mem_wd !== 32'h1122_AA44) begin bad++; $display("FAIL sb_c2_wd: got %h want 1122aa44", bus.mem_wd); end
    total++; if (bus.stall !== 1'b0) begin bad++; $display("FAIL sb_c2_stall: got %b want 0", bus.stall); end
    total++; if (bus.rdata !== 32'h0) begin bad++; $display("FAIL sb_c2_rdata: got %h want 0", bus.rdata); end
    @(negedge clk);
    drive(1, 0, 2'b10, 0, 32'h08, 32'h0);
    #1;
    total++; if (bus.rdata !== 32'h1122_AA44) begin bad++; $display("FAIL sb_readback: got %h want 1122aa44", bus.rdata); end
  endtask

  task automatic test_half_rmw;
    @(negedge clk);
    drive(1, 1, 2'b01, 0, 32'h0A, 32'h1234_BEEF);
    #1;
    total++; if (bus.stall !== 1'b1) begin bad++; $display("FAIL sh_c1_stall: got %b want 1", bus.stall); end
    @(negedge clk);
    #1;
    total++; if (bus.mem_wd !== 32'hBEEF_AA44 || bus.mem_we !== 1'b1) begin bad++; $display("FAIL sh_c2: got we=%b wd=%h want 1 beefaa44", bus.mem_we, bus.mem_wd); end
    @(negedge clk);
    drive(1, 0, 2'b10, 0, 32'h08, 32'h0);
    #1;
    total++; if (bus.rdata !== 32'hBEEF_AA44) begin bad++; $display("FAIL sh_readback: got %h want beefaa44", bus.rdata); end
  endtask

  task automatic test_back_to_back;
    preload(6'd4, 32'h0);
    @(negedge clk);
    drive(1, 1, 2'b00, 0, 32'h10, 32'h55);
    #1;
    total++; if (bus.stall !== 1'b1) begin bad++; $display("FAIL b2b_c1_stall: got %b want 1", bus.stall); end
    @(negedge clk);
    #1;
    total++; if (bus.stall !== 1'b0 || bus.mem_wd !== 32'h0000_0055) begin bad++; $display("FAIL b2b_c2: got stall=%b wd=%h want 0 00000055", bus.stall, bus.mem_wd); end
    @(negedge clk);
    drive(1, 1, 2'b00, 0, 32'h13, 32'h66);
    #1;
    total++; if (bus.stall !== 1'b1 || bus.mem_we !== 1'b0) begin bad++; $display("FAIL b2b_c3: got stall=%b we=%b want 1 0", bus.stall, bus.mem_we); end
    @(negedge clk);
    #1;
    total++; if (bus.mem_we !== 1'b1 || bus.mem_wd !== 32'h6600_0055) begin bad++; $display("FAIL b2b_c4: got we=%b wd=%h want 1 66000055", bus.mem_we, bus.mem_wd); end
    @(negedge clk);
    drive(1, 0, 2'b10, 0, 32'h10, 32'h0);
    #1;
    total++; if (bus.rdata !== 32'h6600_0055) begin bad++; $display("FAIL b2b_readback: got %h want 66000055", bus.rdata); end
  endtask

  task automatic test_rst_mid_rmw;
    preload(6'd3, 32'hCAFE_F00D);
    @(negedge clk);
    drive(1, 1, 2'b01, 0, 32'h0C, 32'h0000_1234);
    #1;
    total++; if (bus.stall !== 1'b1) begin bad++; $display("FAIL rstmid_c1_stall: got %b want 1", bus.stall); end
    @(negedge clk);
    rst = 1'b1;
    #1;
    total++; if (bus.mem_we !== 1'b0) begin bad++; $display("FAIL rstmid_we: got %b want 0", bus.mem_we); end
    @(negedge clk);
    rst = 1'b0;
    drive(0, 0, 2'b10, 0, 32'h0C, 32'h0);
    #1;
    total++; if (bus.stall !== 1'b0 || bus.mem_we !== 1'b0) begin bad++; $display("FAIL rstmid_after: got stall=%b we=%b want 0 0", bus.stall, bus.mem_we); end
    @(negedge clk);
    drive(1, 0, 2'b10, 0, 32'h0C, 32'h0);
    #1;
    total++; if (bus.rdata !== 32'hCAFE_F00D) begin bad++; $display("FAIL rstmid_word3: got %h want cafef00d", bus.rdata); end
  endtask

  task automatic test_range;
    preload(6'd0, 32'h5A5A_5A5A);
    preload(6'd63, 32'hA5A5_A5A5);
    @(negedge clk);
    drive(1, 1, 2'b10, 0, 32'h100, 32'hDEAD_DEAD);
    #1;
    total++; if (bus.mem_we !== 1'b0 || bus.stall !== 1'b0) begin bad++; $display("FAIL range_sw: got we=%b stall=%b want 0 0", bus.mem_we, bus.stall); end
    @(negedge clk);
    drive(1, 0, 2'b10, 0, 32'h100, 32'h0);
    #1;
    total++; if (bus.rdata !== 32'h0) begin bad++; $display("FAIL range_lw: got %h want 0", bus.rdata); end
    @(negedge clk);
    drive(1, 1, 2'b00, 0, 32'h101, 32'h77);
    #1;
    total++; if (bus.stall !== 1'b0 || bus.mem_we !== 1'b0) begin bad++; $display("FAIL range_sb: got stall=%b we=%b want 0 0", bus.stall, bus.mem_we); end
    @(negedge clk);
    drive(1, 0, 2'b10, 0, 32'h00, 32'h0);
    #1;
    total++; if (bus.rdata !== 32'h5A5A_5A5A) begin bad++; $display("FAIL range_alias: got %h want 5a5a5a5a", bus.rdata); end
    @(negedge clk);
    drive(1, 0, 2'b10, 0, 32'hFC, 32'h0);
    #1;
    total++; if (bus.rdata !== 32'hA5A5_A5A5) begin bad++; $display("FAIL range_last: got %h want a5a5a5a5", bus.rdata); end
  endtask

  task automatic test_misalign;
    @(negedge clk);
    drive(1, 1, 2'b10, 0, 32'h0A, 32'h1111_2222);
    #1;
`ifdef LSU_MISALIGN_TRAP_EN
    total++; if (bus.misalign !== 1'b1) begin bad++; $display("FAIL mis_flag: got %b want 1", bus.misalign); end
    total++; if (bus.mem_we !== 1'b0 || bus.stall !== 1'b0) begin bad++; $display("FAIL mis_ctl: got we=%b stall=%b want 0 0", bus.mem_we, bus.stall); end
    @(negedge clk);
    drive(0, 0, 2'b10, 0, 32'h0, 32'h0);
    #1;
    total++; if (bus.misalign !== 1'b1) begin bad++; $display("FAIL mis_sticky: got %b want 1", bus.misalign); end
    @(negedge clk);
    drive(1, 0, 2'b10, 0, 32'h08, 32'h0);
    #1;
    total++; if (bus.rdata !== 32'hBEEF_AA44) begin bad++; $display("FAIL mis_nowrite: got %h want beefaa44", bus.rdata); end
    @(negedge clk);
    drive(1, 0, 2'b01, 0, 32'h15, 32'h0);
    #1;
    total++; if (bus.rdata !== 32'h0) begin bad++; $display("FAIL mis_lh_rdata: got %h want 0", bus.rdata); end
    @(negedge clk);
    rst = 1'b1;
    drive(0, 0, 2'b10, 0, 32'h0, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++; if (bus.misalign !== 1'b0) begin bad++; $display("FAIL mis_cleared: got %b want 0", bus.misalign); end
`else
    total++; if (bus.misalign !== 1'b0) begin bad++; $display("FAIL mis_flag: got %b want 0", bus.misalign); end
    total++; if (bus.mem_we !== 1'b1 || bus.mem_addr !== 32'h08) begin bad++; $display("FAIL mis_force: got we=%b addr=%h want 1 00000008", bus.mem_we, bus.mem_addr); end
    @(negedge clk);
    drive(1, 0, 2'b10, 0, 32'h0B, 32'h0);
    #1;
    total++; if (bus.rdata !== 32'h1111_2222) begin bad++; $display("FAIL mis_readback: got %h want 11112222", bus.rdata); end
    @(negedge clk);
    drive(1, 0, 2'b01, 0, 32'h15, 32'h0);
    #1;
    total++; if (bus.rdata !== 32'h0000_7F02) begin bad++; $display("FAIL mis_lh_force: got %h want 00007f02", bus.rdata); end
`endif
  endtask

  initial begin
    rst    = 1'b1;
    pre_en = 1'b0;
    pre_idx = '0;
    pre_val = '0;
    drive(0, 0, 2'b10, 0, 32'h0, 32'h0);
    test_reset();
    test_load_ext();
    test_word_store();
    test_byte_rmw();
    test_half_rmw();
    test_back_to_back();
    test_rst_mid_rmw();
    test_range();
    test_misalign();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lsu_subword_ctrl.md
Name: lsu_subword_ctrl

Overview:
Load/store controller directly upstream of the word-addressed data memory (synchronous write, asynchronous read, word write only). Converts CPU byte/half/word loads and stores into word accesses. Loads are extracted and sign- or zero-extended. Sub-word stores use a 2-cycle read-modify-write that stalls the CPU.

Parameters:
MEM_WORDS, 64, number of 32-bit words in data memory; used for out-of-range write suppression
BIG_ENDIAN, 0, 0 = byte 0 at bits [7:0]; 1 = byte 0 at bits [31:24]

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous reset, active-high
req_valid  in  1  CPU memory request this cycle
req_we  in  1  1 = store, 0 = load
req_size  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as word)
req_unsigned  in  1  load zero-extend (lbu/lhu); ignored for stores and word loads
req_addr  in  32  byte address from ALU
req_wdata  in  32  store data from rt; low byte/half used for sub-word stores
rdata  out  32  extended load result to writeback mux
stall  out  1  CPU must hold PC and all req_* stable while high
misalign  out  1  access misaligned (half with addr[0]=1, word with addr[1:0]!=0)
mem_addr  out  32  to memory A; always {req_addr[31:2],2'b00}
mem_wd  out  32  to memory WD
mem_we  out  1  to memory WE
mem_rd  in  32  from memory RD, combinational

Behaviour:
- States: IDLE, RMW_WRITE. Reset state IDLE. Reset outputs: stall=0, mem_we=0, misalign=0, merge register=0.
- Loads, IDLE only: zero added latency, stall=0, mem_we=0.
  - rdata = lane select of mem_rd by addr[1:0] (byte) or addr[1] (half), then sign- or zero-extended per req_unsigned.
  - rdata = 0 whenever req_valid=0 or req_we=1.
- Word store (aligned) in IDLE: mem_we=1 and mem_wd=req_wdata in the same cycle; stall=0; stays IDLE.
- Sub-word store in IDLE, cycle 1:
  - mem_we=0, stall=1.
  - merge register <= mem_rd with the target lane replaced by req_wdata[7:0] or [15:0].
  - Next state RMW_WRITE.
- RMW_WRITE, cycle 2:
  - mem_we=1, mem_wd=merge register, stall=0. Next state IDLE.
  - Total 2 cycles per sub-word store. Back-to-back sub-word stores each take 2 cycles.
- The merge register breaks the mem_rd→mem_wd combinational path. mem_wd never depends combinationally on mem_rd.
- Out of range (req_addr[31:2] >= MEM_WORDS): store writes suppressed (mem_we=0, no stall, stays IDLE); loads return 0.
- Misaligned access: behaviour set by the optional feature below.
- rst asserted in RMW_WRITE: go to IDLE, no write issued, stall=0 next cycle.
- req_valid=0: mem_we=0, stall=0, state held in IDLE.
- req_valid dropping in RMW_WRITE: protocol violation. The write still completes with the captured merge value.
- req_size=11 behaves as word.

Optional Feature:
Macro LSU_MISALIGN_TRAP_EN.
- Defined:
  - Misaligned access: misalign=1 combinationally for that request.
  - No memory write; load rdata=0; no stall.
  - A sticky register misalign_seen (readable via misalign OR) holds 1 until rst.
- Undefined:
  - misalign tied 0.
  - Half/word address low bits are forced to alignment (addr[0]=0 for half; addr[1:0]=0 for word) and the access proceeds normally.

Decomposition:
- Shared package mips_mem_pkg:
  - Size encodings SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10.
  - FSM state encodings LSU_IDLE, LSU_RMW_WRITE.
  - Word width 32.
- One natural sub-module, lsu_lane_align: purely combinational. Does load lane extract/extend and store lane merge, both honouring BIG_ENDIAN.
- The FSM, merge register and range/misalign checks stay in the top.

Test Plan:
1. Load extension: preload word 5 = 32'h8081_7F02; lb addr 0x16 -> rdata 32'hFFFF_FF81; lbu same -> 32'h0000_0081; lh addr 0x14 -> 32'h0000_7F02 (little-endian).
2. Word store: sw 32'hDEAD_BEEF to 0x08 -> mem_we=1 same cycle, stall=0; following lw 0x08 returns 32'hDEAD_BEEF.
3. Byte store RMW: word 2 = 32'h1122_3344; sb 32'h0000_00AA to 0x09.
   - Cycle 1: stall=1, mem_we=0.
   - Cycle 2: mem_we=1, mem_wd=32'h1122_AA44.
   - Word 2 then reads 32'h1122_AA44.
4. Reset mid-RMW: sh to 0x0C, assert rst during RMW_WRITE -> mem_we=0 that cycle, word 3 unchanged, stall=0 after.
5. Misalign with LSU_MISALIGN_TRAP_EN: sw to 0x0A -> misalign=1, mem_we=0, flag stays 1 until rst. Without the macro: write lands at word 2.
6. Range: sw to 0x100 (word 64, MEM_WORDS=64) -> mem_we=0, no stall; lw 0x100 -> rdata 0.
